// File: rtl/ridecore_mem_pkg.sv
// Shared types and line geometry for the ridecore instruction-fetch path.
package ridecore_mem_pkg;

  localparam int LINE_BYTES = 16;
  localparam int LINE_INSNS = 4;

  typedef logic [127:0] line_t;
  typedef logic [31:0]  insn_t;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/ridecore_fetch_line_buf.sv
// One fetch line register with load enable and a slot-select read port.
module ridecore_fetch_line_buf
  import ridecore_mem_pkg::*;
(
  input  logic       clk,
  input  logic       load,
  input  line_t      din,
  input  logic [1:0] sel,
  output line_t      line_q,
  output insn_t      insn
);

  always_ff @(posedge clk) begin
    if (load) line_q <= din;
  end

  always_comb begin
    insn = line_q[31:0];
    case (sel)
      2'd0: insn = line_q[31:0];
      2'd1: insn = line_q[63:32];
      2'd2: insn = line_q[95:64];
      2'd3: insn = line_q[127:96];
      default: insn = line_q[31:0];
    endcase
  end

endmodule

// File: rtl/ridecore_fetch_streamer.sv
// Line-based instruction fetch unit: requests 16-byte lines and streams 32-bit words out.
// Defining RIDECORE_FETCH_PREFETCH_EN enables a next-line prefetch buffer.
module ridecore_fetch_streamer
  import ridecore_mem_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  line_t             imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              insn_valid,
  input  logic              insn_ready,
  output insn_t             insn_data,
  output logic [ADDR_W-1:0] insn_pc
);

  localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(LINE_BYTES);
  localparam logic [ADDR_W-1:0] RESET_LINE = {RESET_PC[ADDR_W-1:4], 4'b0};

  fetch_state_e      state;
  logic [ADDR_W-1:0] line_pc;
  logic [1:0]        slot;
  logic [ADDR_W-1:0] redirect_line;
  logic              handshake;
  logic              last_slot;
  logic              buf_load;
  line_t             buf_din;
  line_t             main_line;
  insn_t             main_insn;
  logic              unused_bits;

  assign redirect_line = {redirect_pc[ADDR_W-1:4], 4'b0};
  assign insn_valid    = (state == S_DRAIN);
  assign handshake     = insn_valid && insn_ready;
  assign last_slot     = handshake && (slot == 2'd3);
  assign insn_data     = insn_valid ? main_insn : '0;
  assign insn_pc       = insn_valid ? (line_pc + ADDR_W'({slot, 2'b00})) : '0;

`ifdef RIDECORE_FETCH_PREFETCH_EN
  logic  pf_valid;
  logic  pf_aged;
  logic  pf_load;
  logic  pf_advance;
  line_t pf_line;
  insn_t pf_insn;

  // The next line answers during the second drain cycle, once its address has been sampled.
  assign pf_load     = (state == S_DRAIN) && pf_aged && !pf_valid;
  assign pf_advance  = last_slot && pf_valid;
  assign buf_load    = (state == S_WAIT) || pf_advance;
  assign buf_din     = pf_advance ? pf_line : imem_data;
  assign unused_bits = ^{main_line, pf_insn, redirect_pc[1:0]};

  ridecore_fetch_line_buf u_pf_buf (
    .clk    (clk),
    .load   (pf_load),
    .din    (imem_data),
    .sel    (slot),
    .line_q (pf_line),
    .insn   (pf_insn)
  );
`else
  assign buf_load    = (state == S_WAIT);
  assign buf_din     = imem_data;
  assign unused_bits = ^{main_line, redirect_pc[1:0]};
`endif

  ridecore_fetch_line_buf u_line_buf (
    .clk    (clk),
    .load   (buf_load),
    .din    (buf_din),
    .sel    (slot),
    .line_q (main_line),
    .insn   (main_insn)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_REQ;
      line_pc   <= RESET_LINE;
      slot      <= RESET_PC[3:2];
      imem_addr <= RESET_LINE;
`ifdef RIDECORE_FETCH_PREFETCH_EN
      pf_valid  <= 1'b0;
      pf_aged   <= 1'b0;
`endif
    end else if (redirect_valid) begin
      state     <= S_REQ;
      line_pc   <= redirect_line;
      slot      <= redirect_pc[3:2];
      imem_addr <= redirect_line;
`ifdef RIDECORE_FETCH_PREFETCH_EN
      pf_valid  <= 1'b0;
      pf_aged   <= 1'b0;
`endif
    end else begin
      case (state)
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          state <= S_DRAIN;
`ifdef RIDECORE_FETCH_PREFETCH_EN
          imem_addr <= line_pc + LINE_STEP;
          pf_valid  <= 1'b0;
          pf_aged   <= 1'b0;
`endif
        end
        S_DRAIN: begin
`ifdef RIDECORE_FETCH_PREFETCH_EN
          pf_aged <= 1'b1;
          if (pf_load) pf_valid <= 1'b1;
`endif
          if (handshake) slot <= slot + 2'd1;
          if (last_slot) begin
            line_pc <= line_pc + LINE_STEP;
`ifdef RIDECORE_FETCH_PREFETCH_EN
            pf_valid <= 1'b0;
            if (pf_valid) begin
              imem_addr <= line_pc + (LINE_STEP << 1);
              pf_aged   <= 1'b0;
            end else begin
              // Next line address is already on the bus, so only the capture cycle remains.
              state <= S_WAIT;
            end
`else
            imem_addr <= line_pc + LINE_STEP;
            state     <= S_REQ;
`endif
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ridecore_fetch_streamer.sv
// Scoreboard bench for ridecore_fetch_streamer: expected pc stream queued by the driver, checked by a monitor.
module tb_ridecore_fetch_streamer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  imem_addr;
  logic [127:0] imem_data = '0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic         insn_valid;
  logic         insn_ready = 1'b0;
  logic [31:0]  insn_data;
  logic [31:0]  insn_pc;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] next_push;

  int          since = -1;
  bit          stall_pend = 1'b0;
  logic [31:0] stall_pc;
  logic [31:0] stall_data;
  int          cyc = 0;
  int          t_c = -100;
  int          t_10 = -200;
  bit          rec_en = 1'b0;
  int          hs_count = 0;

  ridecore_fetch_streamer #(
    .ADDR_W   (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn_data      (insn_data),
    .insn_pc        (insn_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory model: the line at the sampled address appears one edge later.
  always @(posedge clk) begin
    imem_data <= {word_at(imem_addr + 32'd12), word_at(imem_addr + 32'd8),
                  word_at(imem_addr + 32'd4), word_at(imem_addr)};
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic topUp();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_push);
      next_push = next_push + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] start);
    exp_q.delete();
    next_push = {start[31:2], 2'b00};
    topUp();
  endtask

  task automatic applyStimulus(input logic rdy, input logic rst, input logic redir, input logic [31:0] rpc);
    insn_ready     = rdy;
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    if (rst) restart(RESET_PC);
    else if (redir) restart(rpc);
    else topUp();
  endtask

  // Monitor: inputs are stable at the falling edge, so valid && ready here is the handshake of the next edge.
  always @(negedge clk) begin : monitor
    logic        hs;
    logic        trig;
    logic [31:0] e;
    cyc++;
    hs = insn_valid && insn_ready;
    if (stall_pend) begin
      checkOutput("stall_valid", 32'(insn_valid), 32'd1);
      checkOutput("stall_pc", insn_pc, stall_pc);
      checkOutput("stall_data", insn_data, stall_data);
    end
    if (since >= 1) checkOutput("valid_latency", 32'(insn_valid), 32'(since == 3));
    if (hs) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: got pc 0x%08h, expected no instruction (queue empty)", insn_pc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("insn_pc", insn_pc, e);
        checkOutput("insn_data", insn_data, word_at(e));
      end
      if (rec_en && insn_pc == 32'h0000_000C) t_c = cyc;
      if (rec_en && insn_pc == 32'h0000_0010) t_10 = cyc;
    end
    stall_pend = insn_valid && !insn_ready && !redirect_valid && !reset;
    stall_pc   = insn_pc;
    stall_data = insn_data;
    trig = reset || redirect_valid;
`ifndef RIDECORE_FETCH_PREFETCH_EN
    trig = trig || (hs && insn_pc[3:2] == 2'd3);
`endif
    if (trig) since = 1;
    else if (since >= 1 && since < 3) since++;
    else since = -1;
  end

  initial begin
    logic [31:0] t;
    int          r;
    logic        rdy;

    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", 32'(insn_valid), 32'd0);
    checkOutput("rst_data", insn_data, 32'h0);
    checkOutput("rst_pc", insn_pc, 32'h0);

    $display("[TB] reset release and first line");
    rec_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_req_addr", imem_addr, 32'h0);
    checkOutput("t1_wait_valid", 32'(insn_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_first_valid", 32'(insn_valid), 32'd1);
    checkOutput("t1_first_pc", insn_pc, 32'h0);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef RIDECORE_FETCH_PREFETCH_EN
    checkOutput("t1_next_line_pc", insn_pc, 32'h10);
`else
    checkOutput("t1_next_addr", imem_addr, 32'h10);
    checkOutput("t1_bubble_valid", 32'(insn_valid), 32'd0);
`endif
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    rec_en = 1'b0;
`ifdef RIDECORE_FETCH_PREFETCH_EN
    checkOutput("t1_line_gap", 32'(t_10 - t_c), 32'd1);
`else
    checkOutput("t1_line_gap", 32'(t_10 - t_c), 32'd3);
`endif

    $display("[TB] redirect to 0x1008");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_1008);
    checkOutput("t2_addr", imem_addr, 32'h0000_1000);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t2_first_pc", insn_pc, 32'h0000_1008);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] backpressure at 0x4");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h4);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_hold_pc", insn_pc, 32'h4);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    end
    checkOutput("t3_hold_data", insn_data, word_at(32'h4));
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] redirect together with handshake");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h8);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t4_pc8", insn_pc, 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    checkOutput("t4_valid_drop", 32'(insn_valid), 32'd0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t4_target_pc", insn_pc, 32'h40);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] address wrap");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t5_top_pc", insn_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t5_wrap_addr", imem_addr, 32'h0);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 99);
      rdy = ($urandom_range(0, 3) != 0);
      if (r < 1) begin
        applyStimulus(rdy, 1'b1, 1'b0, 32'h0);
      end else if (r < 5) begin
        t = $urandom;
        if (r == 4) t = 32'hFFFF_FFC0 | 32'($urandom_range(0, 63));
        applyStimulus(rdy, 1'b0, 1'b1, t);
      end else begin
        applyStimulus(rdy, 1'b0, 1'b0, 32'h0);
      end
    end
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("handshakes_seen", 32'(hs_count >= 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
